// File: rtl/f1_light_seq.sv
// rtl/f1_light_seq.sv - parametrised start-light sequencer with LFSR random hold
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   en           one-cycle tick strobe; all step and hold timing counts en cycles
//   trigger      start request, sampled in IDLE
//   abort        false start / cancel, sampled in LIGHTS and HOLD
//   data_out     lamp pattern, thermometer coded from the LSB
//   cmd_seq      high while a sequence is running (LIGHTS or HOLD)
//   cmd_delay    high during the random hold only
//   lights_out   one-cycle pulse when the lamps go out normally
//   false_start  sticky abort flag, cleared on the next start
//   hold_ticks   random hold length captured for the current or last sequence
module f1_light_seq #(
    parameter int                N_LIGHTS   = 8,
    parameter int                STEP_TICKS = 1,
    parameter int                LFSR_W     = 7,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 7'h60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                abort,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                cmd_seq,
    output logic                cmd_delay,
    output logic                lights_out,
    output logic                false_start,
    output logic [LFSR_W-1:0]   hold_ticks
);

    localparam int LW = $clog2(N_LIGHTS + 1);
    localparam int SW = $clog2(STEP_TICKS + 1);
    localparam logic [LW-1:0] LAST_LAMP = LW'(N_LIGHTS - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LIGHTS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] hold_cnt;
    logic [LW-1:0]     lamp_cnt;
    logic [SW-1:0]     step_cnt;

    assign cmd_seq   = (state != IDLE);
    assign cmd_delay = (state == HOLD);

    // Free-running so the captured hold length depends on when the
    // sequence happened to start; seeded with 1 so it can never lock at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_W'(1);
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            data_out    <= '0;
            lights_out  <= 1'b0;
            false_start <= 1'b0;
            hold_ticks  <= '0;
            hold_cnt    <= '0;
            lamp_cnt    <= '0;
            step_cnt    <= '0;
        end else begin
            lights_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state       <= LIGHTS;
                        data_out    <= N_LIGHTS'(1);
                        lamp_cnt    <= LW'(1);
                        step_cnt    <= '0;
                        false_start <= 1'b0;
                    end
                end
                LIGHTS: begin
                    // abort wins over a tick that would light the next lamp
                    if (abort) begin
                        state       <= IDLE;
                        data_out    <= '0;
                        false_start <= 1'b1;
                    end else if (en) begin
                        if (step_cnt == LAST_STEP) begin
                            step_cnt <= '0;
                            data_out <= {data_out[N_LIGHTS-2:0], 1'b1};
                            lamp_cnt <= lamp_cnt + LW'(1);
                            // this tick lights the final lamp: start the hold
                            if (lamp_cnt == LAST_LAMP) begin
                                state      <= HOLD;
                                hold_ticks <= lfsr;
                                hold_cnt   <= lfsr;
                            end
                        end else begin
                            step_cnt <= step_cnt + SW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state       <= IDLE;
                        data_out    <= '0;
                        false_start <= 1'b1;
                    end else if (en) begin
                        if (hold_cnt == LFSR_W'(1)) begin
                            state      <= IDLE;
                            data_out   <= '0;
                            lights_out <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - LFSR_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    data_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/f1_light_seq.md
# f1_light_seq

Parametrised start-light sequencer and the successor to the fixed 8-light F1 FSM. On a start request it lights N_LIGHTS lamps one at a time, spaced by a programmable number of tick strobes. It then holds all lamps on for a pseudo-random number of ticks drawn from an internal LFSR, and finally extinguishes them with a "lights out" pulse. An abort input detects a false start. The block sits between the clock-tick divider (which drives `en`) and the lamp driver / reaction-timer logic.

## Interface
- N_LIGHTS, 8, number of lamps (2..16)
- STEP_TICKS, 1, `en` strobes between successive lamps (≥1)
- LFSR_W, 7, width of the random hold generator and of `hold_ticks` (3..16)
- LFSR_TAPS, 7'h60, Fibonacci feedback tap mask (default x^7+x^6+1); must give a maximal-length sequence
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  tick strobe, one clk cycle wide; all step and hold timing counts only cycles where en=1
- trigger  in  1  start request, level-sampled in IDLE
- abort  in  1  false-start / cancel, level-sampled in LIGHTS and HOLD
- data_out  out  N_LIGHTS  lamp pattern, thermometer coded from the LSB
- cmd_seq  out  1  high in LIGHTS and HOLD
- cmd_delay  out  1  high in HOLD only
- lights_out  out  1  one-cycle pulse when the lamps go out normally
- false_start  out  1  sticky flag; set by abort, cleared on the next start
- hold_ticks  out  LFSR_W  random hold length captured for the current or last sequence

## Operation
- States:
  - IDLE: lamps off.
  - LIGHTS: lamps filling.
  - HOLD: all lamps on, random wait.
- Outputs are registered. cmd_seq and cmd_delay are decoded from the registered state.
- LFSR:
  - Free-running on every clk edge, independent of en.
  - Shifts left; new LSB = XOR of the bits selected by LFSR_TAPS.
  - Reset seed is 1. The value is never 0.
- IDLE → LIGHTS:
  - Condition: trigger=1 at a clk edge (en not required).
  - Actions: data_out=1, lamp count=1, step counter cleared, false_start cleared.
- LIGHTS:
  - Each en=1 cycle increments the step counter.
  - On the en cycle that completes STEP_TICKS strobes, the step counter clears and data_out becomes {data_out[N_LIGHTS-2:0],1'b1}.
- LIGHTS → HOLD:
  - Occurs on the same edge that lights the final lamp (data_out becomes all ones).
  - hold_ticks and the hold counter load the current LFSR value.
- HOLD:
  - The hold counter decrements on each en=1 cycle.
  - On the en cycle where the counter equals 1, the block goes to IDLE. On that edge data_out=0 and lights_out=1 for one cycle.
  - The hold therefore lasts exactly hold_ticks strobes, with a range of 1..2^LFSR_W−1.
- abort:
  - abort=1 in LIGHTS or HOLD → IDLE, data_out=0, false_start=1, no lights_out pulse.
  - abort has priority over a completing tick in the same cycle.
  - abort is ignored in IDLE.
- trigger is ignored in LIGHTS and HOLD. If trigger is held high through the end of a sequence, a new sequence starts on the edge after the return to IDLE.
- hold_ticks keeps its value until the next LIGHTS→HOLD transition.
- Counter widths:
  - Lamp count: $clog2(N_LIGHTS+1).
  - Step counter: $clog2(STEP_TICKS+1).
  - Counters never wrap within a sequence.

## Timing
- Reset values (rst=0, effective immediately without clk):
  - state IDLE
  - data_out 0
  - cmd_seq 0
  - cmd_delay 0
  - lights_out 0
  - false_start 0
  - hold_ticks 0
  - LFSR 1
- Reset asserted mid-sequence aborts with no lights_out pulse and does not set false_start.
- Trigger to first lamp: 1 clk edge.
- Lamp k+1 appears STEP_TICKS en strobes after lamp k.
- cmd_delay rises on the same edge that data_out reaches all ones.
- Lights-out: exactly hold_ticks en strobes after cmd_delay rises. cmd_seq, cmd_delay and data_out fall on the same edge that lights_out pulses.
- Total sequence length: (N_LIGHTS−1)·STEP_TICKS + hold_ticks en strobes, plus 1 clk for the start.

## Test plan
- Reset: drive rst=0 mid-HOLD with clk stopped → all outputs 0 at once. Release rst, trigger → first hold_ticks equals the LFSR model value seeded with 1.
- Normal run, N_LIGHTS=8, STEP_TICKS=1, en every cycle, 1-cycle trigger:
  - data_out steps 0x01, 0x03, …, 0xFF on consecutive edges.
  - cmd_delay rises with 0xFF.
  - lights_out pulses exactly hold_ticks cycles later.
  - data_out returns to 0x00.
- Spacing, STEP_TICKS=3, en every 4th cycle: each lamp increment occurs after 3 strobes (12 clk). data_out is stable between strobes.
- Abort in HOLD: abort=1 while data_out=0xFF → next edge data_out=0, cmd_seq=0, false_start=1, no lights_out. The next trigger clears false_start and lights 0x01.
- Collisions:
  - abort coincides with the tick that would light lamp 7 → abort wins and data_out=0.
  - trigger held high through a sequence → ignored while busy; a new sequence starts 1 edge after lights_out.
- Parameter sweep, N_LIGHTS=2 and 16, LFSR_W=3: full thermometer sequences. Hold lengths over 7 runs cover all of 1..7 with none equal to 0.
